// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: nibble-serial add/subtract that time-shares one 4-bit adder
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4,
  localparam int N = 4 * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int IW = $clog2(WORDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WORDS-1:0][3:0] la, lb, work, res;
  logic [IW-1:0] idx;
  logic [3:0] s;
  logic lsub, carry, co, accept, last;
  four_bit_adder u_add (
    .a   (la[idx]),
    .b   (lb[idx] ^ {4{lsub}}),
    .cin (carry),
    .s   (s),
    .cout(co)
  );
  always_comb begin
    accept = start && state != RUN;
    last = idx == IW'(WORDS - 1);
    state_n = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
    res = work;
    res[idx] = s;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      la <= '0;
      lb <= '0;
      lsub <= 1'b0;
      idx <= '0;
      carry <= 1'b0;
      work <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      la <= a;
      lb <= b;
      lsub <= sub;
      idx <= '0;
      carry <= sub;
    end else if (state == RUN) begin
      work <= res;
      carry <= co;
      idx <= idx + 1'b1;
      if (last) begin
        sum <= res;
        cout <= co;
        ovf <= (la[WORDS-1][3] == (lb[WORDS-1][3] ^ lsub)) && (s[3] != la[WORDS-1][3]);
      end
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: scoreboard bench for the nibble-serial add/subtract sequencer
module tb_wide_add_sequencer;
  typedef struct packed {logic [15:0] s; logic c; logic o;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0, sum;
  logic busy, done, cout, ovf;
  int checks = 0, fails = 0;
  exp_t q[$];
  logic [15:0] last_sum = '0;

  wide_add_sequencer #(.WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: sum=%h cout=%b ovf=%b with nothing expected", sum, cout, ovf);
      end else begin
        e = q.pop_front();
        if ({sum, cout, ovf} !== {e.s, e.c, e.o}) begin
          fails++;
          $display("FAIL result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                   sum, cout, ovf, e.s, e.c, e.o);
        end
      end
    end
  end

  task automatic push(input logic [15:0] es, input logic ec, input logic eo);
    exp_t e;
    e.s = es; e.c = ec; e.o = eo;
    q.push_back(e);
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb2, input logic ts,
                        input logic [15:0] es, input logic ec, input logic eo);
    int nb;
    bit seen;
    push(es, ec, eo);
    @(posedge clk); #1 start = 1'b1; a = ta; b = tb2; sub = ts;
    @(posedge clk); #1 start = 1'b0;
    nb = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (busy) nb++;
    end
    checks++;
    if (!seen || nb != 4) begin
      fails++;
      $display("FAIL latency %h%s%h: done_seen=%0d busy_cycles=%0d, want done_seen=1 busy_cycles=4",
               ta, ts ? "-" : "+", tb2, seen, nb);
    end
    @(negedge clk);
    checks++;
    if (sum !== es || done !== 1'b0) begin
      fails++;
      $display("FAIL hold: sum=%h done=%b, want sum=%h done=0", sum, done, es);
    end
    last_sum = es;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({sum, cout, ovf, busy, done} !== 21'b0) begin
      fails++;
      $display("FAIL reset_state: sum=%h cout=%b ovf=%b busy=%b done=%b, want all 0", sum, cout, ovf, busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
  endtask

  task automatic test_carry;
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
  endtask

  task automatic test_sub;
    run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    logic [15:0] ra, rb, es;
    logic rs, ec, eo;
    int sa, sb, r;
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      sa = int'($signed(ra)); sb = int'($signed(rb));
      r = rs ? sa - sb : sa + sb;
      es = rs ? ra - rb : ra + rb;
      ec = rs ? (ra >= rb) : ((32'(ra) + 32'(rb)) > 32'hFFFF);
      eo = (r > 32767) || (r < -32768);
      run_op(ra, rb, rs, es, ec, eo);
    end
  endtask

  task automatic test_ignore_start;
    int nd;
    bit held;
    push(16'h3333, 1'b0, 1'b0);
    @(posedge clk); #1 start = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    @(posedge clk); #1 start = 1'b0; a = '0; b = '0;
    nd = 0; held = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) nd++;
      else if (nd == 0 && sum !== last_sum) held = 0;
    end
    checks++;
    if (nd != 1) begin
      fails++;
      $display("FAIL ignore_start_dones: got %0d done pulses, want 1", nd);
    end
    checks++;
    if (!held) begin
      fails++;
      $display("FAIL ignore_start_hold: sum changed before done, want %h held", last_sum);
    end
    last_sum = 16'h3333;
  endtask

  task automatic test_back_to_back;
    bit seen;
    int n;
    push(16'h2345, 1'b0, 1'b0);
    @(posedge clk); #1 start = 1'b1; a = 16'h1234; b = 16'h1111; sub = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    start = 1'b1; a = 16'h0F0F; b = 16'h00F1; sub = 1'b0;
    push(16'h1000, 1'b0, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(negedge clk);
      if (done) n = i;
    end
    checks++;
    if (!seen || n != 5) begin
      fails++;
      $display("FAIL back_to_back_spacing: first_done=%0d second_done_after=%0d cycles, want 1 and 5", seen, n);
    end
    @(negedge clk);
    last_sum = 16'h1000;
  endtask

  task automatic test_reset_mid;
    int nd;
    @(posedge clk); #1 start = 1'b1; a = 16'h5555; b = 16'h1111; sub = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({sum, cout, ovf, busy, done} !== 21'b0) begin
      fails++;
      $display("FAIL reset_mid_outputs: sum=%h cout=%b ovf=%b busy=%b done=%b, want all 0", sum, cout, ovf, busy, done);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    checks++;
    if (nd != 0) begin
      fails++;
      $display("FAIL reset_mid_abort: %0d busy/done cycles after release, want 0", nd);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d results never produced, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
